// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the single-port RAM master.
// Holds the default RAM geometry, the master state encoding and the
// request record the master latches at acceptance.
package sp_ram_pkg;

    // Default RAM geometry: 128 locations x 8 bits.
    localparam int SP_RAM_ADDR_W = 7;
    localparam int SP_RAM_DATA_W = 8;

    // Phase counter width; covers READ_LAT-1 (max 3) and TURN_CYCLES-1 (max 2).
    localparam int SP_RAM_CNT_W  = 2;

    // Width of the optional accepted-request statistics counters.
    localparam int SP_RAM_STAT_W = 16;

    // Master sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } sp_ram_state_e;

    // One client request at the default geometry.
    typedef struct packed {
        logic                     we;
        logic [SP_RAM_ADDR_W-1:0] addr;
        logic [SP_RAM_DATA_W-1:0] wdata;
    } sp_ram_req_t;

    // Terminal value of the phase counter for a phase lasting n cycles (n >= 1).
    function automatic logic [SP_RAM_CNT_W-1:0] sp_ram_last(input int n);
        return (n > 0) ? SP_RAM_CNT_W'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/sp_ram_sat_cnt.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sp_ram_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step by one unless already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sp_ram_master.sv
// Initiator for a single-port RAM with a shared bidirectional data bus.
// Accepts read/write requests, drives the RAM we/addr/data pins, owns the
// bus direction and the write-to-read turnaround, and returns read data on
// a one-cycle response strobe.
// Optional statistics (accepted write/read counters) are built when the
// macro SP_RAM_MASTER_STATS_EN is defined.
//
// Request handshake: a request transfers on a rising clk_i edge where
// req_valid_i and req_ready_o are both high. req_ready_o is high exactly
// when the master is IDLE and does not depend on req_valid_i. The request
// fields are captured at that edge, so the client may change them freely
// afterwards. rsp_valid_o is a single-cycle pulse with no back-pressure.
module sp_ram_master
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W      = SP_RAM_ADDR_W,
    parameter int DATA_W      = SP_RAM_DATA_W,
    parameter int READ_LAT    = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    inout  wire  [DATA_W-1:0] ram_data_io,
`ifdef SP_RAM_MASTER_STATS_EN
    output logic [15:0]       wr_cnt_o,
    output logic [15:0]       rd_cnt_o,
`endif
    output logic [1:0]        dbg_state_o
);

    localparam logic [SP_RAM_CNT_W-1:0] RD_LAST   = sp_ram_last(READ_LAT);
    localparam logic [SP_RAM_CNT_W-1:0] TURN_LAST = sp_ram_last(TURN_CYCLES);
    localparam logic [SP_RAM_CNT_W-1:0] CNT_ONE   = SP_RAM_CNT_W'(1);

    sp_ram_state_e           state_q, state_d;
    logic [SP_RAM_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                    accept;

    assign accept = req_valid_i && (state_q == IDLE);

    // Next-state, request capture, phase counting and read-data capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr_i;
                    cnt_d  = '0;
                    if (req_we_i) begin
                        wdata_d = req_wdata_i;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                // The RAM captures at the edge closing this single cycle.
                cnt_d   = '0;
                state_d = (TURN_CYCLES > 0) ? TURN : IDLE;
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            READ: begin
                if (cnt_q == RD_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ram_data_io;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // RAM pins decode straight from state so reset drops we and frees the
    // bus immediately; the bus is driven only while we is high.
    assign ram_we_o    = (state_q == WRITE);
    assign ram_addr_o  = addr_q;
    assign ram_data_io = ram_we_o ? wdata_q : {DATA_W{1'bz}};

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign dbg_state_o = state_q;

`ifdef SP_RAM_MASTER_STATS_EN
    sp_ram_sat_cnt #(.W(SP_RAM_STAT_W)) u_wr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (accept && req_we_i),
        .cnt_o (wr_cnt_o)
    );

    sp_ram_sat_cnt #(.W(SP_RAM_STAT_W)) u_rd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (accept && !req_we_i),
        .cnt_o (rd_cnt_o)
    );
`endif

endmodule
